// File: rtl/axis_to_gmii_ser.sv
// ---------------------------------------------------------------------------
// axis_to_gmii_ser
//   AXI-Stream to GMII byte serialiser for the 10G->1G TX bridge.
//   Beats ({tlast, tkeep, tdata}) are buffered in a DEPTH-word FIFO and sent
//   as bytes, LSB first, one per byte_ce strike. A frame starts once
//   START_THRESH words are buffered or a complete frame (tlast word) is
//   present. If the FIFO runs dry mid-frame, the frame is aborted with
//   tx_er and the rest of that frame is discarded. Every frame end or abort
//   is followed by an inter-frame gap of IFG_BYTES idle byte slots.
//
// Ports
//   tx_clk_out      in   clock, rising edge, drives all logic
//   rst_n           in   asynchronous reset, active low
//   s_axis_tvalid   in   input beat valid
//   s_axis_tready   out  FIFO not full
//   s_axis_tdata    in   beat data, byte 0 = [7:0] is sent first
//   s_axis_tkeep    in   byte enables
//   s_axis_tlast    in   last beat of frame
//   byte_ce         in   GMII byte slot strobe
//   gmii_tx_en      out  GMII enable
//   gmii_tx_er      out  GMII error (underrun abort)
//   gmii_txd        out  GMII data
//   underrun        out  one-clock pulse on abort
//   frame_cnt       out  completed (non-aborted) frames, wrapping
// ---------------------------------------------------------------------------
module axis_to_gmii_ser #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 4,
  parameter int START_THRESH = 2,
  parameter int IFG_BYTES    = 12
) (
  input  logic                  tx_clk_out,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  byte_ce,
  output logic                  gmii_tx_en,
  output logic                  gmii_tx_er,
  output logic [7:0]            gmii_txd,
  output logic                  underrun,
  output logic [15:0]           frame_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int IDXW   = $clog2(KEEP_W);
  localparam int WORD_W = 1 + KEEP_W + DATA_W;
  localparam int IW     = $clog2(IFG_BYTES + 1) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_IFG  = 2'd3;

  // ---------------------------------------------------------------- FIFO --
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_last_cnt;
  logic              r_tready;

  logic              w_store;
  logic              w_pop;
  logic              w_has_head;
  logic [WORD_W-1:0] w_head;
  logic [DATA_W-1:0] w_head_data;
  logic [KEEP_W-1:0] w_head_keep;
  logic              w_head_last;
  logic [CW-1:0]     w_count_nxt;
  logic [CW-1:0]     w_last_cnt_nxt;

  // An empty non-last beat carries nothing: accept it but never store it, so
  // it costs neither FIFO space nor a byte slot.
  assign w_store = s_axis_tvalid && r_tready &&
                   ((s_axis_tkeep != '0) || s_axis_tlast);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_head_keep = w_head[DATA_W +: KEEP_W];
  assign w_head_last = w_head[WORD_W-1];
  assign w_has_head  = (r_count != '0);

  assign w_count_nxt    = r_count + CW'(w_store) - CW'(w_pop);
  assign w_last_cnt_nxt = r_last_cnt + CW'(w_store && s_axis_tlast)
                                     - CW'(w_pop && w_head_last);

  // NOTE: storage array has no reset; contents are only read behind r_count,
  // so clearing it would just add reset fan-out.
  always_ff @(posedge tx_clk_out) begin
    if (w_store) r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge tx_clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last_cnt <= '0;
      r_tready   <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_last_cnt <= w_last_cnt_nxt;
      // Registered from the next count, so it reads as !full of the current
      // count and is held low throughout reset.
      r_tready   <= (w_count_nxt != CW'(DEPTH));
    end
  end

  assign s_axis_tready = r_tready;

  // ------------------------------------------------------ byte selection --
  logic [KEEP_W-1:0] r_sent;     // bytes of the head word already sent
  logic [KEEP_W-1:0] w_rem;
  logic [KEEP_W-1:0] w_onehot;
  logic [IDXW-1:0]   w_idx;
  logic [7:0]        w_byte;
  logic              w_last_byte;

  assign w_rem = w_head_keep & ~r_sent;

  // Lowest remaining enabled byte; keep=0 bytes are skipped without a slot.
  always_comb begin
    w_idx = '0;
    for (int i = KEEP_W - 1; i >= 0; i--) begin
      if (w_rem[i]) w_idx = IDXW'(i);
    end
  end

  assign w_onehot    = KEEP_W'(1) << w_idx;
  assign w_byte      = w_head_data[{w_idx, 3'b000} +: 8];
  assign w_last_byte = ((w_rem & ~w_onehot) == '0);

  // ----------------------------------------------------------------- FSM --
  logic [1:0]    r_state;
  logic          r_eof;          // final byte of the frame has been sent
  logic [IW-1:0] r_ifg_cnt;
  logic          r_tx_en;
  logic          r_tx_er;
  logic [7:0]    r_txd;
  logic          r_underrun;
  logic [15:0]   r_frame_cnt;

  logic [1:0]        w_state_nxt;
  logic              w_eof_nxt;
  logic [KEEP_W-1:0] w_sent_nxt;
  logic [IW-1:0]     w_ifg_nxt;
  logic              w_tx_en_nxt;
  logic              w_tx_er_nxt;
  logic [7:0]        w_txd_nxt;
  logic              w_underrun_nxt;
  logic [15:0]       w_frame_cnt_nxt;
  logic              w_emit;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_eof_nxt       = r_eof;
    w_sent_nxt      = r_sent;
    w_ifg_nxt       = r_ifg_cnt;
    w_tx_en_nxt     = r_tx_en;
    w_tx_er_nxt     = r_tx_er;
    w_txd_nxt       = r_txd;
    w_underrun_nxt  = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
    w_pop           = 1'b0;
    w_emit          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (byte_ce) begin
          w_tx_en_nxt = 1'b0;
          w_tx_er_nxt = 1'b0;
          w_txd_nxt   = 8'h00;
          if (w_has_head &&
              (r_count >= CW'(START_THRESH) || r_last_cnt != '0)) begin
            if (w_rem == '0) begin
              // A payload-free tlast word with no frame around it.
              w_pop = 1'b1;
            end else begin
              w_emit      = 1'b1;
              w_state_nxt = S_SEND;
            end
          end
        end
      end

      S_SEND: begin
        if (byte_ce) begin
          w_tx_er_nxt = 1'b0;
          if (r_eof || (w_has_head && w_rem == '0)) begin
            // End slot: either the last byte already went out, or the head
            // is a keep=0 tlast word closing the frame. This slot is the
            // first of the inter-frame gap.
            w_pop           = !r_eof;
            w_eof_nxt       = 1'b0;
            w_tx_en_nxt     = 1'b0;
            w_txd_nxt       = 8'h00;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            w_ifg_nxt       = IW'(1);
            w_state_nxt     = (IFG_BYTES > 1) ? S_IFG : S_IDLE;
          end else if (!w_has_head) begin
            w_tx_en_nxt    = 1'b1;
            w_tx_er_nxt    = 1'b1;
            w_txd_nxt      = 8'h00;
            w_underrun_nxt = 1'b1;
            w_state_nxt    = S_DROP;
          end else begin
            w_emit = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (byte_ce) begin
          w_tx_en_nxt = 1'b0;
          w_tx_er_nxt = 1'b0;
          w_txd_nxt   = 8'h00;
        end
        // Flush runs every clock so the aborted frame clears quickly.
        if (w_has_head) begin
          w_pop = 1'b1;
          if (w_head_last) begin
            w_ifg_nxt   = '0;
            w_state_nxt = S_IFG;
          end
        end
      end

      default: begin  // S_IFG
        if (byte_ce) begin
          w_tx_en_nxt = 1'b0;
          w_tx_er_nxt = 1'b0;
          w_txd_nxt   = 8'h00;
          if (r_ifg_cnt + IW'(1) >= IW'(IFG_BYTES)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_ifg_nxt = r_ifg_cnt + IW'(1);
          end
        end
      end
    endcase

    if (w_emit) begin
      w_tx_en_nxt = 1'b1;
      w_txd_nxt   = w_byte;
      w_sent_nxt  = r_sent | w_onehot;
      if (w_last_byte) begin
        w_pop     = 1'b1;
        w_eof_nxt = w_head_last;
      end
    end

    if (w_pop) w_sent_nxt = '0;
  end

  always_ff @(posedge tx_clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_eof       <= 1'b0;
      r_sent      <= '0;
      r_ifg_cnt   <= '0;
      r_tx_en     <= 1'b0;
      r_tx_er     <= 1'b0;
      r_txd       <= 8'h00;
      r_underrun  <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_eof       <= w_eof_nxt;
      r_sent      <= w_sent_nxt;
      r_ifg_cnt   <= w_ifg_nxt;
      r_tx_en     <= w_tx_en_nxt;
      r_tx_er     <= w_tx_er_nxt;
      r_txd       <= w_txd_nxt;
      r_underrun  <= w_underrun_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  assign gmii_tx_en = r_tx_en;
  assign gmii_tx_er = r_tx_er;
  assign gmii_txd   = r_txd;
  assign underrun   = r_underrun;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_axis_to_gmii_ser.sv
// ---------------------------------------------------------------------------
// tb_axis_to_gmii_ser
//   Directed scoreboard bench for axis_to_gmii_ser (default parameters).
//   Stimulus pushes the expected GMII byte stream into a queue; a monitor
//   compares every tx_en slot against it, checks idle slots and output hold
//   between byte_ce strikes, and enforces the inter-frame gap.
// ---------------------------------------------------------------------------
module tb_axis_to_gmii_ser;

  localparam int IFG = 12;

  typedef struct packed {
    logic       er;
    logic [7:0] d;
  } exp_t;

  logic        tx_clk_out = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        byte_ce = 1'b0;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [7:0]  gmii_txd;
  logic        underrun;
  logic [15:0] frame_cnt;

  axis_to_gmii_ser dut (
    .tx_clk_out    (tx_clk_out),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .byte_ce       (byte_ce),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .gmii_txd      (gmii_txd),
    .underrun      (underrun),
    .frame_cnt     (frame_cnt)
  );

  always #5 tx_clk_out = ~tx_clk_out;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b1;
  bit   in_frame = 1'b0;
  bit   seen_frame = 1'b0;
  int   idle_slots = 0;
  int   bytes_emitted = 0;
  int   ce_div = 1;
  int   ce_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // byte_ce: 0 = off, 1 = every clock, N = every Nth clock
  initial forever begin
    @(negedge tx_clk_out);
    if (ce_div <= 0) begin
      byte_ce = 1'b0;
    end else begin
      byte_ce = (ce_cnt == 0);
      ce_cnt  = (ce_cnt + 1 >= ce_div) ? 0 : ce_cnt + 1;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       ce_edge;
    logic [9:0] prev;
    exp_t       e;
    prev = '0;
    forever begin
      @(posedge tx_clk_out);
      ce_edge = byte_ce;
      #1;
      if (mon_en && rst_n) begin
        if (ce_edge) begin
          if (gmii_tx_en) begin
            if (!in_frame && seen_frame && idle_slots < IFG) begin
              n_checks++;
              n_errors++;
              $display("FAIL ifg_gap: got %0d idle slots expected >= %0d",
                       idle_slots, IFG);
            end
            in_frame   = 1'b1;
            idle_slots = 0;
            bytes_emitted++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_byte: got txd %0h with empty queue",
                       gmii_txd);
            end else begin
              e = exp_q.pop_front();
              check("txd", 32'(gmii_txd), 32'(e.d));
              check("tx_er", 32'(gmii_tx_er), 32'(e.er));
              check("underrun", 32'(underrun), 32'(e.er));
            end
          end else begin
            if (in_frame) seen_frame = 1'b1;
            in_frame = 1'b0;
            idle_slots++;
            check("idle_slot", 32'({gmii_tx_er, gmii_txd}), 32'h0);
          end
        end else begin
          check("hold", 32'({gmii_tx_en, gmii_tx_er, gmii_txd}), 32'(prev));
        end
      end
      prev = {gmii_tx_en, gmii_tx_er, gmii_txd};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [7:0] base);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic exp_beat(input logic [63:0] d, input logic [7:0] k);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) begin
        e.er = 1'b0;
        e.d  = d[i*8 +: 8];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic exp_err();
    exp_t e;
    e.er = 1'b1;
    e.d  = 8'h00;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    while (!s_axis_tready && n < 2000) begin
      @(negedge tx_clk_out);
      n++;
    end
    if (!s_axis_tready) timeout("send_beat");
    @(negedge tx_clk_out);
  endtask

  task automatic axis_idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int settle);
    int n = 0;
    while ((exp_q.size() != 0 || gmii_tx_en) && n < 3000) begin
      @(negedge tx_clk_out);
      n++;
    end
    if (n >= 3000) timeout("drain");
    repeat (settle) @(negedge tx_clk_out);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, 32'(gmii_tx_en), 32'h0);
    check({tag, "_tx_er"}, 32'(gmii_tx_er), 32'h0);
    check({tag, "_txd"}, 32'(gmii_txd), 32'h0);
    check({tag, "_underrun"}, 32'(underrun), 32'h0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'h0);
  endtask

  initial begin
    int n;
    int base;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge tx_clk_out);
    rst_n = 1'b1;
    @(posedge tx_clk_out);
    #2;
    check("reset_tready_rise", 32'(s_axis_tready), 32'h1);
    @(negedge tx_clk_out);

    // T1: two full beats, byte_ce every clock -> bytes 00..0F
    ce_div = 1;
    exp_beat(64'h0706050403020100, 8'hFF);
    exp_beat(64'h0F0E0D0C0B0A0908, 8'hFF);
    send_beat(64'h0706050403020100, 8'hFF, 1'b0);
    send_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1);
    axis_idle();
    wait_drain(30);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // T2: single short last beat, byte_ce every 5th clock -> 88 77 66 55
    ce_div = 5;
    exp_beat(64'h1122334455667788, 8'h0F);
    send_beat(64'h1122334455667788, 8'h0F, 1'b1);
    axis_idle();
    wait_drain(150);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // T3: sparse keep 0xA5 -> bytes 11 33 66 88 back to back
    ce_div = 1;
    exp_beat(64'h8877665544332211, 8'hA5);
    send_beat(64'h8877665544332211, 8'hA5, 1'b1);
    axis_idle();
    wait_drain(30);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

    // T4: input stalls after two non-last beats -> abort on byte 16
    exp_beat(mk(8'h40), 8'hFF);
    exp_beat(mk(8'h48), 8'hFF);
    exp_err();
    send_beat(mk(8'h40), 8'hFF, 1'b0);
    send_beat(mk(8'h48), 8'hFF, 1'b0);
    axis_idle();
    n = 0;
    while (!underrun && n < 500) begin
      @(posedge tx_clk_out);
      #1;
      n++;
    end
    check("t4_underrun_seen", 32'(underrun), 32'h1);
    @(negedge tx_clk_out);
    // Rest of the aborted frame: must be dropped
    send_beat(mk(8'h50), 8'hFF, 1'b0);
    send_beat(mk(8'h58), 8'hFF, 1'b1);
    // Next frame is clean
    exp_beat(mk(8'h60), 8'hFF);
    exp_beat(mk(8'h68), 8'h3C);
    send_beat(mk(8'h60), 8'hFF, 1'b0);
    send_beat(mk(8'h68), 8'h3C, 1'b1);
    axis_idle();
    wait_drain(30);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd4);

    // T5: byte_ce off, push DEPTH+1 beats -> tready low after DEPTH accepts
    ce_div = 0;
    repeat (2) @(negedge tx_clk_out);
    for (int b = 0; b < 5; b++) exp_beat(mk(8'(8'h80 + 8 * b)), 8'hFF);
    for (int b = 0; b < 4; b++) send_beat(mk(8'(8'h80 + 8 * b)), 8'hFF, 1'b0);
    check("t5_tready_full", 32'(s_axis_tready), 32'h0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk(8'hA0);
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b1;
    repeat (10) @(negedge tx_clk_out);
    check("t5_tready_held", 32'(s_axis_tready), 32'h0);
    base   = bytes_emitted;
    ce_div = 1;
    n = 0;
    while (!s_axis_tready && n < 200) begin
      @(negedge tx_clk_out);
      n++;
    end
    check("t5_tready_rise", 32'(s_axis_tready), 32'h1);
    check("t5_bytes_at_rise", 32'(bytes_emitted - base), 32'd8);
    @(negedge tx_clk_out);
    axis_idle();
    wait_drain(30);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd5);

    // T6: reset mid-frame, then a clean frame
    mon_en = 1'b0;
    send_beat(mk(8'hC0), 8'hFF, 1'b0);
    send_beat(mk(8'hC8), 8'hFF, 1'b0);
    axis_idle();
    n = 0;
    while (!gmii_tx_en && n < 100) begin
      @(negedge tx_clk_out);
      n++;
    end
    check("t6_frame_started", 32'(gmii_tx_en), 32'h1);
    repeat (3) @(negedge tx_clk_out);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (3) @(negedge tx_clk_out);
    rst_n = 1'b1;
    @(posedge tx_clk_out);
    #2;
    check("t6_tready_rise", 32'(s_axis_tready), 32'h1);
    check("t6_frame_cnt_cleared", 32'(frame_cnt), 32'h0);
    exp_q.delete();
    in_frame   = 1'b0;
    seen_frame = 1'b0;
    idle_slots = 0;
    mon_en     = 1'b1;
    @(negedge tx_clk_out);
    exp_beat(mk(8'hE0), 8'hFF);
    exp_beat(mk(8'hE8), 8'h81);
    send_beat(mk(8'hE0), 8'hFF, 1'b0);
    send_beat(mk(8'hE8), 8'h81, 1'b1);
    axis_idle();
    wait_drain(30);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
